// File: rtl/mixer_pkg.sv
// Shared types and width helpers for the
// time-multiplexed voice mixer.
package mixer_pkg;

  typedef enum logic {
    MIX_AVERAGE,
    MIX_SATURATE
  } mix_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } mixer_state_t;

  function automatic int acc_width(
    input int width,
    input int channels
  );
    return width + $clog2(channels);
  endfunction

endpackage

// File: rtl/mixer_scale.sv
// Combinational accumulator-to-sample scaler:
// floor average or clamp with clip flag.
module mixer_scale
  import mixer_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CHANNELS = 4,
  localparam int ACC_W = acc_width(WIDTH, CHANNELS)
) (
  input  logic signed [ACC_W-1:0] acc,
  input  mix_mode_t               mode,
  output logic [WIDTH-1:0]        scaled,
  output logic                    clip
);

  localparam int SH = ACC_W - WIDTH;

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(SH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(SH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Dropping the low SH bits is an arithmetic
  // shift with rounding toward -inf.
  logic [WIDTH-1:0] avg;
  assign avg = acc[ACC_W-1:SH];

  always_comb begin
    scaled = avg;
    clip   = 1'b0;
    unique case (mode)
      MIX_AVERAGE: scaled = avg;
      MIX_SATURATE: begin
        if (acc > MAXV) begin
          scaled = MAXV[WIDTH-1:0];
          clip   = 1'b1;
        end else if (acc < MINV) begin
          scaled = MINV[WIDTH-1:0];
          clip   = 1'b1;
        end else begin
          scaled = acc[WIDTH-1:0];
        end
      end
    endcase
  end

endmodule

// File: rtl/mixer_seq.sv
// Voice mixer: one shared accumulator, one
// channel per clock, handshaked in and out.
module mixer_seq
  import mixer_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CHANNELS = 4,
  parameter int CLIP_W = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS-1:0][WIDTH-1:0] samples,
  input  logic [CHANNELS-1:0]            ch_enable,
  input  logic                           mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_sample,
  output logic [CLIP_W-1:0]              clip_count,
  input  logic                           clip_clear
);

  localparam int ACC_W = acc_width(WIDTH, CHANNELS);
  localparam int IDX_W = $clog2(CHANNELS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(CHANNELS - 1);

  if (CHANNELS < 2 ||
      (CHANNELS & (CHANNELS - 1)) != 0)
  begin : g_bad_channels
    $error("mixer_seq: CHANNELS must be pow2 >= 2");
  end

  mixer_state_t state, state_n;

  logic [CHANNELS-1:0][WIDTH-1:0] smp_q;
  logic [CHANNELS-1:0]            en_q;
  mix_mode_t                      mode_q;
  logic signed [ACC_W-1:0]        acc;
  logic [IDX_W-1:0]               idx;

  logic                    accept;
  logic                    finish;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;
  logic [WIDTH-1:0]        scaled;
  logic                    clip;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (idx == LAST) begin
          finish  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          accept   = in_valid;
          state_n  = in_valid ? ACCUM : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    term = '0;
    if (en_q[idx])
      term = {{IDX_W{smp_q[idx][WIDTH-1]}},
              smp_q[idx]};
  end

  assign sum = acc + term;

  mixer_scale #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_scale (
    .acc    (sum),
    .mode   (mode_q),
    .scaled (scaled),
    .clip   (clip)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      smp_q      <= '0;
      en_q       <= '0;
      mode_q     <= MIX_AVERAGE;
      acc        <= '0;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      clip_count <= '0;
    end else begin
      if (accept) begin
        smp_q  <= samples;
        en_q   <= ch_enable;
        mode_q <= mix_mode_t'(mode);
        acc    <= '0;
        idx    <= '0;
      end else if (state == ACCUM) begin
        acc <= sum;
        idx <= idx + 1'b1;
      end

      if (finish) begin
        out_sample <= scaled;
        out_valid  <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end

      // Clear beats a coincident clip event.
      if (clip_clear)
        clip_count <= '0;
      else if (finish && clip && clip_count != '1)
        clip_count <= clip_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mixer_seq.sv
// Directed bench for mixer_seq with a frame-level
// reference model checked every cycle.
module tb_mixer_seq;

  localparam int W  = 24;
  localparam int CH = 4;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic [CH-1:0][W-1:0] samples;
  logic [CH-1:0] ch_enable;
  logic mode;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_sample;
  logic [CW-1:0] clip_count;
  logic clip_clear;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mixer_seq #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .CLIP_W   (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .samples    (samples),
    .ch_enable  (ch_enable),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .clip_count (clip_count),
    .clip_clear (clip_clear)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // Reference mix in plain integer arithmetic.
  function automatic void mix(
    input logic [CH-1:0][W-1:0] s,
    input logic [CH-1:0] en,
    input bit md,
    output logic [W-1:0] r,
    output bit c);
    int total;
    int q;
    total = 0;
    c = 0;
    for (int i = 0; i < CH; i++)
      if (en[i]) total += int'($signed(s[i]));
    if (!md) begin
      q = total >>> $clog2(CH);
      r = q[W-1:0];
    end else if (total > (1 << (W-1)) - 1) begin
      r = {1'b0, {(W-1){1'b1}}};
      c = 1;
    end else if (total < -(1 << (W-1))) begin
      r = {1'b1, {(W-1){1'b0}}};
      c = 1;
    end else begin
      r = total[W-1:0];
    end
  endfunction

  bit m_live = 0;
  int m_cnt = 0;
  bit m_valid = 0;
  logic [W-1:0] m_sample = '0;
  logic [W-1:0] p_sample = '0;
  bit p_clip = 0;
  int m_clip = 0;
  bit m_acc;
  bit m_fin;

  function automatic bit m_rdy();
    return m_cnt == 0 && (!m_valid || out_ready);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_live = 1; m_cnt = 0; m_valid = 0;
      m_sample = '0; m_clip = 0;
    end else if (m_live) begin
      m_acc = m_rdy() && in_valid;
      m_fin = (m_cnt == 1);
      if (m_fin) begin
        m_valid = 1;
        m_sample = p_sample;
      end else if (m_cnt == 0 && m_valid && out_ready) begin
        m_valid = 0;
      end
      if (clip_clear) m_clip = 0;
      else if (m_fin && p_clip && m_clip < (1 << CW) - 1)
        m_clip++;
      if (m_cnt > 0) m_cnt--;
      if (m_acc) begin
        mix(samples, ch_enable, mode, p_sample, p_clip);
        m_cnt = CH;
      end
    end
  end

  always @(negedge clock) begin
    if (m_live && !reset) begin
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_rdy()});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("m_out_sample", 32'(out_sample), 32'(m_sample));
      chk("m_clip_count", 32'(clip_count), 32'(m_clip));
    end
  end

  task automatic send(input logic [W-1:0] a, b, c, d,
                      input logic [CH-1:0] en,
                      input bit md,
                      output int acc_cyc);
    samples = {d, c, b, a};
    ch_enable = en;
    mode = md;
    in_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #2;
        acc_cyc = cyc;
        break;
      end
      @(posedge clock);
      #2;
    end
    in_valid = 1'b0;
    samples = {CH{24'h5A5A5A}};
    ch_enable = '1;
    mode = ~md;
    if (acc_cyc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic get(input int acc_cyc,
                     input logic [W-1:0] exp,
                     input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk(nm, 32'(out_sample), 32'(exp));
      chk({nm, "_lat"}, cyc - acc_cyc, CH);
    end
    @(posedge clock);
    #2 out_ready = 1'b1;
    @(posedge clock);
    #2 out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clip_clear = 1'b0;
    samples = '0;
    ch_enable = '0;
    mode = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_sample", 32'(out_sample), 0);
    chk("rst_clip", 32'(clip_count), 0);
    @(posedge clock);
    #2;

    send(24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF,
         4'hF, 0, a);
    get(a, 24'h3FFFFF, "avg_full");
    chk("avg_full_clip", 32'(clip_count), 0);

    send(24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF,
         4'hF, 1, a);
    get(a, 24'h7FFFFF, "sat_pos");
    chk("sat_pos_clip", 32'(clip_count), 1);

    send(24'd3, 24'd1, 24'd2, 24'd0, 4'hF, 0, a);
    get(a, 24'h000001, "avg_small");

    send(24'h800000, 24'h800000, 24'h800000, 24'h800000,
         4'hF, 1, a);
    get(a, 24'h800000, "sat_neg");
    chk("sat_neg_clip", 32'(clip_count), 2);

    send(24'h800000, 24'h800000, 24'h800000, 24'h800000,
         4'hF, 0, a);
    get(a, 24'h800000, "avg_neg");
    chk("avg_neg_clip", 32'(clip_count), 2);

    send(24'hF, 24'hF, 24'hF, 24'hF, 4'b0101, 0, a);
    get(a, 24'h000007, "mute_0101");

    send(24'hF, 24'hF, 24'hF, 24'hF, 4'b0000, 0, a);
    get(a, 24'h000000, "mute_all");

    // Backpressure, then back-to-back acceptance.
    send(24'd1, 24'd2, 24'd3, 24'd4, 4'hF, 0, a);
    for (int i = 0; i < 30 && !out_valid; i++)
      @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_sample", 32'(out_sample), 2);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      @(negedge clock);
    end
    @(posedge clock);
    #2;
    samples = {24'd5, 24'd5, 24'd5, 24'd5};
    ch_enable = 4'hF;
    mode = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_pulse_ready", {31'd0, in_ready}, 1);
    @(posedge clock);
    #2;
    a = cyc;
    in_valid = 1'b0;
    out_ready = 1'b0;
    samples = '0;
    get(a, 24'd5, "bp_next");

    // Reset in the second accumulate cycle.
    send(24'd7, 24'd7, 24'd7, 24'd7, 4'hF, 1, a);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_sample", 32'(out_sample), 0);
    chk("mid_rst_clip", 32'(clip_count), 0);
    chk("mid_rst_ready", {31'd0, in_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("mid_rst_quiet", {31'd0, out_valid}, 0);
    end
    @(posedge clock);
    #2;
    send(24'd7, 24'd7, 24'd7, 24'd7, 4'hF, 1, a);
    get(a, 24'h00001C, "post_rst");

    // Drive the clip counter into saturation.
    for (int i = 0; i < 17; i++) begin
      send(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
           24'h7FFFFF, 4'hF, 1, a);
      get(a, 24'h7FFFFF, "clip_run");
      chk("clip_run_cnt", 32'(clip_count),
          (i + 1 < 15) ? i + 1 : 15);
    end
    chk("clip_hold", 32'(clip_count), 32'hF);

    send(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
         24'h7FFFFF, 4'hF, 1, a);
    repeat (3) @(posedge clock);
    #2 clip_clear = 1'b1;
    @(posedge clock);
    #2 clip_clear = 1'b0;
    get(a, 24'h7FFFFF, "clear_vs_clip");
    chk("clear_vs_clip_cnt", 32'(clip_count), 0);

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
